// File: rtl/quadrilatero_register_lsu.sv
// quadrilatero_register_lsu
//   Execution end of the matrix LSU issue path. One load/store is accepted per
//   start_i pulse while idle; busy_o stays high until the done_o pulse.
//   Loads fetch a tile word by word over an OBI-style port and write it into
//   the matrix register file one row at a time (rows beyond conf_rows and
//   words beyond conf_cols are written as zero, so a load always writes all
//   N_ROWS rows). Stores read register rows and write the active words out.
//
// Optional feature: define QUADRILATERO_LSU_ERR_EN to add err_o. A bus error
//   (mem_err_i with mem_rvalid_i) aborts the instruction, and a misaligned
//   base address or stride finishes immediately; err_o pulses with done_o.
//   Without it, errors are ignored and the low two address bits are dropped.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i, instr_*_i      issue pulse with instruction fields
//   conf_rows_i/conf_cols_i active tile shape (clamped to 1..max)
//   busy_o, done_o          in-progress flag, one-cycle completion pulse
//   mem_*                   single-outstanding OBI-style data port
//   rf_*                    register row write port / row read port (1-cycle)
//   err_o                   error pulse (only with QUADRILATERO_LSU_ERR_EN)

module quadrilatero_register_lsu #(
  parameter int N_ROWS = 4,
  parameter int RLEN   = 128,
  parameter int N_REGS = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic                          instr_store_i,
  input  logic [$clog2(N_REGS)-1:0]     instr_reg_i,
  input  logic [31:0]                   instr_addr_i,
  input  logic [31:0]                   instr_stride_i,
  input  logic [$clog2(N_ROWS):0]       conf_rows_i,
  input  logic [$clog2(RLEN/32):0]      conf_cols_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          mem_req_o,
  input  logic                          mem_gnt_i,
  output logic                          mem_we_o,
  output logic [31:0]                   mem_addr_o,
  output logic [3:0]                    mem_be_o,
  output logic [31:0]                   mem_wdata_o,
  input  logic                          mem_rvalid_i,
  input  logic [31:0]                   mem_rdata_i,
  input  logic                          mem_err_i,
  output logic                          rf_we_o,
  output logic                          rf_re_o,
  output logic [$clog2(N_REGS)-1:0]     rf_reg_o,
  output logic [$clog2(N_ROWS)-1:0]     rf_row_o,
  output logic [RLEN-1:0]               rf_wdata_o,
  input  logic [RLEN-1:0]               rf_rdata_i
`ifdef QUADRILATERO_LSU_ERR_EN
  , output logic                        err_o
`endif
);

  localparam int WORDS = RLEN / 32;
  localparam int RI    = $clog2(N_ROWS);
  localparam int WI    = $clog2(WORDS);
  localparam int RW    = RI + 1;
  localparam int CW    = WI + 1;
  localparam int GI    = $clog2(N_REGS);

  typedef enum logic [3:0] {
    S_IDLE, S_LD_REQ, S_LD_WAIT, S_LD_WB,
    S_ST_RD, S_ST_CAP, S_ST_REQ, S_ST_WAIT, S_DONE
  } state_t;

  state_t          r_state, w_next;
  logic            r_busy;
  logic            r_store;
  logic [GI-1:0]   r_reg;
  logic [31:0]     r_base;     // byte address of word 0 of row r_r
  logic [31:0]     r_stride;
  logic [RW-1:0]   r_rows;
  logic [CW-1:0]   r_cols;
  logic [RI-1:0]   r_r;
  logic [WI-1:0]   r_w;
  logic [RLEN-1:0] r_buf;

  logic [RW-1:0]   w_rows;
  logic [CW-1:0]   w_cols;
  logic [31:0]     w_word_addr;
  logic [31:0]     w_st_word;
  logic [RLEN-1:0] w_ld_row;
  logic            w_rsp, w_err_rsp, w_misalign;
  logic            w_last_word, w_last_row, w_next_row_active, w_row_active;

  // Clamp the tile shape into 1..max.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_rows = conf_rows_i;
    if (conf_rows_i == '0)               w_rows = RW'(1);
    else if (conf_rows_i > RW'(N_ROWS))  w_rows = RW'(N_ROWS);
    w_cols = conf_cols_i;
    if (conf_cols_i == '0)               w_cols = CW'(1);
    else if (conf_cols_i > CW'(WORDS))   w_cols = CW'(WORDS);
  end

`ifdef QUADRILATERO_LSU_ERR_EN
  logic r_err;
  assign w_misalign = (|instr_addr_i[1:0]) | (|instr_stride_i[1:0]);
  assign w_err_rsp  = w_rsp & mem_err_i;
  assign err_o      = (r_state == S_DONE) & r_err;
`else
  logic w_unused;
  assign w_unused   = mem_err_i ^ (^instr_addr_i[1:0]) ^ (^instr_stride_i[1:0]);
  assign w_misalign = 1'b0;
  assign w_err_rsp  = 1'b0;
`endif

  // A response may arrive in the grant cycle (zero-latency slave), so it is
  // accepted in the request state as well as in the wait state.
  assign w_rsp = mem_rvalid_i &
                 ((r_state == S_LD_WAIT) || (r_state == S_ST_WAIT) ||
                  (((r_state == S_LD_REQ) || (r_state == S_ST_REQ)) && mem_gnt_i));

  assign w_word_addr       = r_base + {{(30-WI){1'b0}}, r_w, 2'b00};
  assign w_st_word         = r_buf[{r_w, 5'd0} +: 32];
  assign w_last_word       = ({1'b0, r_w} == (r_cols - CW'(1)));
  assign w_last_row        = (r_r == RI'(N_ROWS - 1));
  assign w_next_row_active = (({1'b0, r_r} + RW'(1)) < r_rows);
  assign w_row_active      = ({1'b0, r_r} < r_rows);

  always_comb begin
    w_ld_row = '0;
    for (int i = 0; i < WORDS; i++)
      if (i < int'(r_cols)) w_ld_row[i*32 +: 32] = r_buf[i*32 +: 32];
  end

  // State register.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (start_i) begin
          if (w_misalign)         w_next = S_DONE;
          else if (instr_store_i) w_next = S_ST_RD;
          else                    w_next = S_LD_REQ;
        end
      S_LD_REQ, S_LD_WAIT:
        if (w_rsp) begin
          if (w_err_rsp)        w_next = S_DONE;
          else if (w_last_word) w_next = S_LD_WB;
          else                  w_next = S_LD_REQ;
        end else if ((r_state == S_LD_REQ) && mem_gnt_i) begin
          w_next = S_LD_WAIT;
        end
      S_LD_WB:
        if (w_last_row)             w_next = S_DONE;
        else if (w_next_row_active) w_next = S_LD_REQ;
        else                        w_next = S_LD_WB;   // zero rows, back to back
      S_ST_RD:  w_next = S_ST_CAP;
      S_ST_CAP: w_next = S_ST_REQ;
      S_ST_REQ, S_ST_WAIT:
        if (w_rsp) begin
          if (w_err_rsp)        w_next = S_DONE;
          else if (w_last_word) w_next = (w_last_row || !w_next_row_active) ? S_DONE : S_ST_RD;
          else                  w_next = S_ST_REQ;
        end else if ((r_state == S_ST_REQ) && mem_gnt_i) begin
          w_next = S_ST_WAIT;
        end
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Instruction fields, counters and busy flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_busy   <= 1'b0;
      r_store  <= 1'b0;
      r_reg    <= '0;
      r_base   <= '0;
      r_stride <= '0;
      r_rows   <= RW'(1);
      r_cols   <= CW'(1);
      r_r      <= '0;
      r_w      <= '0;
    end else begin
      if ((r_state == S_IDLE) && start_i) begin
        r_busy   <= 1'b1;
        r_store  <= instr_store_i;
        r_reg    <= instr_reg_i;
        r_base   <= {instr_addr_i[31:2], 2'b00};
        r_stride <= {instr_stride_i[31:2], 2'b00};
        r_rows   <= w_rows;
        r_cols   <= w_cols;
        r_r      <= '0;
        r_w      <= '0;
      end else if (r_state == S_DONE) begin
        r_busy <= 1'b0;
      end

      // Word/row counters move only when the matching response arrives.
      if (w_rsp && !w_err_rsp) begin
        if (w_last_word) begin
          r_w <= '0;
          if (r_store) begin
            r_r    <= r_r + 1'b1;
            r_base <= r_base + r_stride;
          end
        end else begin
          r_w <= r_w + 1'b1;
        end
      end

      if (r_state == S_LD_WB) begin
        r_r    <= r_r + 1'b1;
        r_base <= r_base + r_stride;
      end
    end
  end

  // NOTE: the row buffer has no reset; every word is written before it is consumed.
  always_ff @(posedge clk_i) begin
    if (w_rsp && !w_err_rsp && !r_store) r_buf[{r_w, 5'd0} +: 32] <= mem_rdata_i;
    else if (r_state == S_ST_CAP)        r_buf <= rf_rdata_i;
  end

`ifdef QUADRILATERO_LSU_ERR_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)                               r_err <= 1'b0;
    else if ((r_state == S_IDLE) && start_i) r_err <= w_misalign;
    else if (w_err_rsp)                      r_err <= 1'b1;
  end
`endif

  // Outputs.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    rf_we_o     = 1'b0;
    rf_re_o     = 1'b0;
    rf_wdata_o  = '0;
    done_o      = 1'b0;
    unique case (r_state)
      S_LD_REQ: begin
        mem_req_o  = 1'b1;
        mem_be_o   = 4'hF;
        mem_addr_o = w_word_addr;
      end
      S_ST_REQ: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_be_o    = 4'hF;
        mem_addr_o  = w_word_addr;
        mem_wdata_o = w_st_word;
      end
      S_LD_WB: begin
        rf_we_o    = 1'b1;
        rf_wdata_o = w_row_active ? w_ld_row : '0;
      end
      S_ST_RD: rf_re_o = 1'b1;
      S_DONE:  done_o  = 1'b1;
      default: ;
    endcase
  end

  assign busy_o   = r_busy;
  assign rf_reg_o = r_reg;
  assign rf_row_o = r_r;

endmodule

// File: tb/tb_quadrilatero_register_lsu.sv
// Scoreboard bench for quadrilatero_register_lsu: stimulus pushes expected
// memory requests and register-file writes into queues; a monitor pops and
// compares them whenever the DUT presents a granted request or an rf write.
module tb_quadrilatero_register_lsu;

  localparam int N_ROWS = 4;
  localparam int RLEN   = 128;
  localparam int N_REGS = 8;

  logic        clk, rst_i, start_i, instr_store_i;
  logic [2:0]  instr_reg_i;
  logic [31:0] instr_addr_i, instr_stride_i;
  logic [2:0]  conf_rows_i, conf_cols_i;
  logic        busy_o, done_o, mem_req_o, mem_gnt_i, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_be_o;
  logic        mem_rvalid_i, mem_err_i, rf_we_o, rf_re_o;
  logic [2:0]  rf_reg_o;
  logic [1:0]  rf_row_o;
  logic [127:0] rf_wdata_o, rf_rdata_i;
`ifdef QUADRILATERO_LSU_ERR_EN
  logic        err_o;
  bit          exp_err = 0;
`endif

  quadrilatero_register_lsu #(.N_ROWS(N_ROWS), .RLEN(RLEN), .N_REGS(N_REGS)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .instr_store_i(instr_store_i),
    .instr_reg_i(instr_reg_i), .instr_addr_i(instr_addr_i), .instr_stride_i(instr_stride_i),
    .conf_rows_i(conf_rows_i), .conf_cols_i(conf_cols_i), .busy_o(busy_o), .done_o(done_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i), .rf_we_o(rf_we_o), .rf_re_o(rf_re_o),
    .rf_reg_o(rf_reg_o), .rf_row_o(rf_row_o), .rf_wdata_o(rf_wdata_o), .rf_rdata_i(rf_rdata_i)
`ifdef QUADRILATERO_LSU_ERR_EN
    , .err_o(err_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } req_t;
  typedef struct { logic [2:0] rg; logic [1:0] row; logic [127:0] data; } rfw_t;
  req_t exp_req[$];
  rfw_t exp_rf[$];
  int   done_cnt = 0;

  task automatic push_req(input logic [31:0] a, input logic we, input logic [31:0] d);
    req_t e;
    e.addr = a; e.we = we; e.wdata = d;
    exp_req.push_back(e);
  endtask

  task automatic push_rf(input logic [2:0] rg, input logic [1:0] row, input logic [127:0] d);
    rfw_t e;
    e.rg = rg; e.row = row; e.data = d;
    exp_rf.push_back(e);
  endtask

  // Register contents seen by stores: word w of row r holds 4r+w.
  function automatic logic [127:0] st_row(input logic [1:0] r);
    logic [31:0] b;
    b = 32'(r) * 32'd4;
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  // Memory slave: read data is the inverted word address.
  int          stall_cycles = 0;
  bit          zero_lat     = 1;
  bit          err_en       = 0;
  logic [31:0] err_addr     = 32'h0;
  bit          rsp_pending  = 0;
  logic [31:0] rsp_addr;
  int          stall_cnt    = 0;

  always @(negedge clk) begin
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_err_i    = 1'b0;
    mem_rdata_i  = 32'h0;
    if (rsp_pending) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = ~rsp_addr;
      mem_err_i    = err_en && (rsp_addr == err_addr);
      rsp_pending  = 0;
    end else if (mem_req_o) begin
      if (stall_cnt < stall_cycles) begin
        stall_cnt++;
      end else begin
        stall_cnt = 0;
        mem_gnt_i = 1'b1;
        if (zero_lat) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = ~mem_addr_o;
          mem_err_i    = err_en && (mem_addr_o == err_addr);
        end else begin
          rsp_pending = 1;
          rsp_addr    = mem_addr_o;
        end
      end
    end else begin
      stall_cnt = 0;
    end
  end

  // Register-file read port: data valid the cycle after rf_re_o.
  logic       re_d  = 1'b0;
  logic [1:0] row_d = 2'd0;
  always @(negedge clk) begin
    rf_rdata_i = re_d ? st_row(row_d) : {4{32'hDEADBEEF}};
    re_d       = rf_re_o;
    row_d      = rf_row_o;
  end

  // Monitor.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr, prev_wdata;
  logic        prev_we;
  always begin
    @(negedge clk);
    #1;
    if (!rst_i) begin
      if (mem_req_o && mem_gnt_i) begin
        if (exp_req.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_req: addr %h we %b, none expected", mem_addr_o, mem_we_o);
        end else begin
          req_t e;
          e = exp_req.pop_front();
          check("req_addr", mem_addr_o, e.addr);
          check("req_we", mem_we_o, e.we);
          check("req_be", mem_be_o, 4'hF);
          if (e.we) check("req_wdata", mem_wdata_o, e.wdata);
        end
      end
      if (mem_req_o && !mem_gnt_i && prev_stall) begin
        check("stall_addr_stable", mem_addr_o, prev_addr);
        check("stall_we_stable", mem_we_o, prev_we);
        check("stall_wdata_stable", mem_wdata_o, prev_wdata);
      end
      prev_stall = mem_req_o && !mem_gnt_i;
      prev_addr  = mem_addr_o;
      prev_we    = mem_we_o;
      prev_wdata = mem_wdata_o;
      if (rf_we_o) begin
        if (exp_rf.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rf_write: row %0d data %h, none expected", rf_row_o, rf_wdata_o);
        end else begin
          rfw_t e;
          e = exp_rf.pop_front();
          check("rf_reg", rf_reg_o, e.rg);
          check("rf_row", rf_row_o, e.row);
          check("rf_wdata", rf_wdata_o, e.data);
        end
      end
      if (done_o) begin
        done_cnt++;
`ifdef QUADRILATERO_LSU_ERR_EN
        check("err_with_done", err_o, exp_err);
`endif
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic issue(input logic st, input logic [2:0] rg, input logic [31:0] a,
                       input logic [31:0] s, input logic [2:0] rows, input logic [2:0] cols);
    @(negedge clk);
    check("busy_before_start", busy_o, 1'b0);
    start_i = 1'b1; instr_store_i = st; instr_reg_i = rg;
    instr_addr_i = a; instr_stride_i = s; conf_rows_i = rows; conf_cols_i = cols;
    @(negedge clk);
    start_i = 1'b0;
    #1;
    check("busy_after_start", busy_o, 1'b1);
  endtask

  task automatic finish_instr(input string name, input int exp_done);
    bit seen = 0;
    for (int i = 0; i < 400; i++) begin
      if (done_o) begin
        seen = 1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (!seen) $display("FAIL %s_timeout: no done_o within budget", name);
    check({name, "_done_seen"}, seen, 1'b1);
    @(negedge clk);
    #1;
    check({name, "_busy_low_after"}, busy_o, 1'b0);
    check({name, "_done_count"}, done_cnt, exp_done);
    check({name, "_req_q_empty"}, exp_req.size(), 0);
    check({name, "_rf_q_empty"}, exp_rf.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; start_i = 1'b0; instr_store_i = 1'b0; instr_reg_i = '0;
    instr_addr_i = '0; instr_stride_i = '0; conf_rows_i = '0; conf_cols_i = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_req", mem_req_o, 1'b0);
    check("rst_rf_we", rf_we_o, 1'b0);
    check("rst_rf_re", rf_re_o, 1'b0);
    check("rst_addr", mem_addr_o, 32'h0);
    @(negedge clk);
    rst_i = 1'b0;

    // 1: load 2x2, zero-latency slave.
    zero_lat = 1; stall_cycles = 0;
    push_req(32'h1000, 0, 0); push_req(32'h1004, 0, 0);
    push_req(32'h1010, 0, 0); push_req(32'h1014, 0, 0);
    push_rf(3'd1, 2'd0, 128'h00000000_00000000_FFFFEFFB_FFFFEFFF);
    push_rf(3'd1, 2'd1, 128'h00000000_00000000_FFFFEFEB_FFFFEFEF);
    push_rf(3'd1, 2'd2, 128'h0);
    push_rf(3'd1, 2'd3, 128'h0);
    issue(1'b0, 3'd1, 32'h1000, 32'h10, 3'd2, 3'd2);
    finish_instr("load_2x2", 1);

    // 2: store 4x4, stride 0x40, one-cycle response latency.
    zero_lat = 0;
    for (int r = 0; r < 4; r++)
      for (int w = 0; w < 4; w++)
        push_req(32'h2000 + 32'(r) * 32'h40 + 32'(w) * 4, 1, 32'(r * 4 + w));
    issue(1'b1, 3'd4, 32'h2000, 32'h40, 3'd4, 3'd4);
    finish_instr("store_4x4", 2);

    // 3: grant stalls of 3 cycles, load then store.
    stall_cycles = 3;
    push_req(32'h3000, 0, 0); push_req(32'h3004, 0, 0);
    push_rf(3'd2, 2'd0, 128'h00000000_00000000_FFFFCFFB_FFFFCFFF);
    push_rf(3'd2, 2'd1, 128'h0);
    push_rf(3'd2, 2'd2, 128'h0);
    push_rf(3'd2, 2'd3, 128'h0);
    issue(1'b0, 3'd2, 32'h3000, 32'h20, 3'd1, 3'd2);
    finish_instr("load_stall", 3);
    push_req(32'h4000, 1, 32'h0); push_req(32'h4004, 1, 32'h1);
    issue(1'b1, 3'd5, 32'h4000, 32'h20, 3'd1, 3'd2);
    finish_instr("store_stall", 4);
    stall_cycles = 0;

    // 4: start while busy is ignored.
    zero_lat = 1;
    push_req(32'h5000, 0, 0);
    push_rf(3'd2, 2'd0, 128'h00000000_00000000_00000000_FFFFAFFF);
    push_rf(3'd2, 2'd1, 128'h0);
    push_rf(3'd2, 2'd2, 128'h0);
    push_rf(3'd2, 2'd3, 128'h0);
    issue(1'b0, 3'd2, 32'h5000, 32'h10, 3'd1, 3'd1);
    repeat (2) @(negedge clk);
    start_i = 1'b1; instr_store_i = 1'b1; instr_addr_i = 32'h6000; conf_rows_i = 3'd4; conf_cols_i = 3'd4;
    @(negedge clk);
    start_i = 1'b0;
    finish_instr("start_while_busy", 5);

    // 5: address wrap, rows 0 -> 1, cols 7 -> 4.
    zero_lat = 0;
    push_req(32'hFFFFFFF8, 0, 0); push_req(32'hFFFFFFFC, 0, 0);
    push_req(32'h00000000, 0, 0); push_req(32'h00000004, 0, 0);
    push_rf(3'd6, 2'd0, 128'hFFFFFFFB_FFFFFFFF_00000003_00000007);
    push_rf(3'd6, 2'd1, 128'h0);
    push_rf(3'd6, 2'd2, 128'h0);
    push_rf(3'd6, 2'd3, 128'h0);
    issue(1'b0, 3'd6, 32'hFFFFFFF8, 32'h10, 3'd0, 3'd7);
    finish_instr("addr_wrap", 6);

    // 6: reset in the middle of a stalled request.
    stall_cycles = 50;
    issue(1'b0, 3'd3, 32'h8000, 32'h10, 3'd4, 3'd4);
    repeat (3) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    check("midrst_busy", busy_o, 1'b0);
    check("midrst_req", mem_req_o, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    check("midrst_idle_req", mem_req_o, 1'b0);
    check("midrst_done_count", done_cnt, 6);
    stall_cycles = 0;

`ifdef QUADRILATERO_LSU_ERR_EN
    // 7: bus error on the second beat aborts the load without rf writes.
    zero_lat = 1; err_en = 1; err_addr = 32'h7004; exp_err = 1;
    push_req(32'h7000, 0, 0); push_req(32'h7004, 0, 0);
    issue(1'b0, 3'd1, 32'h7000, 32'h10, 3'd2, 3'd2);
    finish_instr("bus_err", 7);
    // 8: misaligned base completes immediately with no traffic.
    issue(1'b0, 3'd1, 32'h7002, 32'h10, 3'd2, 3'd2);
    finish_instr("misaligned", 8);
    err_en = 0; exp_err = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/quadrilatero_register_lsu.md
Name: quadrilatero_register_lsu

Overview:
- Execution end of the LSU issue path. Accepts one issued matrix load/store per start pulse from the LSU controller and holds busy_o until the instruction completes.
- Loads: fetches a tile from memory over an OBI-style data port, word by word, and writes it into the matrix register file one row at a time.
- Stores: reads register rows and writes the active words to memory.

Parameters:
- N_ROWS, 4, rows per matrix register.
- RLEN, 128, bits per register row; multiple of 32.
- N_REGS, 8, number of matrix registers.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  one-cycle pulse; instruction/config inputs are valid this cycle
- instr_store_i  in  1  1 = store, 0 = load
- instr_reg_i  in  $clog2(N_REGS)  matrix register index
- instr_addr_i  in  32  base byte address
- instr_stride_i  in  32  byte stride between rows
- conf_rows_i  in  $clog2(N_ROWS)+1  active rows, 1..N_ROWS
- conf_cols_i  in  $clog2(RLEN/32)+1  active 32-bit words per row, 1..RLEN/32
- busy_o  out  1  instruction in progress
- done_o  out  1  one-cycle completion pulse
- mem_req_o  out  1  memory request
- mem_gnt_i  in  1  request accepted
- mem_we_o  out  1  write enable
- mem_addr_o  out  32  word address
- mem_be_o  out  4  byte enables; always 4'hF
- mem_wdata_o  out  32  store data
- mem_rvalid_i  in  1  response valid
- mem_rdata_i  in  32  load data
- mem_err_i  in  1  bus error, qualified by mem_rvalid_i
- rf_we_o  out  1  register row write
- rf_re_o  out  1  register row read; rf_rdata_i is valid the next cycle
- rf_reg_o  out  $clog2(N_REGS)  register index
- rf_row_o  out  $clog2(N_ROWS)  row index
- rf_wdata_o  out  RLEN  row write data
- rf_rdata_i  in  RLEN  row read data
- err_o  out  1  error pulse; exists only with the optional feature

Behaviour:
- Reset: all outputs 0; FSM in IDLE; row and word counters 0.
- Captured fields: start_i in IDLE latches instr_* and conf_* and moves to LD_REQ (load) or ST_RD (store).
- busy_o: registered, high from the cycle after start_i until the cycle done_o pulses (inclusive). The controller never pulses start_i in the cycle after its own start, so there is no overlap.
- start_i while busy_o=1 is ignored.
- Addressing: word (r,w) is at addr + r*stride + 4*w, computed modulo 2^32. mem_addr_o[1:0] is forced to 0.
- Outstanding requests: at most one. mem_req_o, mem_addr_o, mem_we_o and mem_wdata_o are held stable until mem_gnt_i. mem_req_o drops the cycle after the grant and is not reasserted until mem_rvalid_i.
- Load states:
  - LD_REQ: request word (r,w).
  - LD_WAIT: on rvalid, put rdata into word w of the row buffer.
  - On rvalid with w == conf_cols-1, go to LD_WB.
  - LD_WB: rf_we_o=1 for one cycle with row r. Words w >= conf_cols are zero.
- Rows r >= conf_rows on load: written as all-zero rows in consecutive cycles, with no memory traffic. A load therefore always writes exactly N_ROWS rows, in order 0..N_ROWS-1.
- Store states:
  - ST_RD: rf_re_o=1 for row r.
  - Next cycle: capture rf_rdata_i into the row buffer.
  - ST_REQ / ST_WAIT: write words 0..conf_cols-1 with mem_we_o=1. mem_wdata_o = buffer[32w +: 32].
  - Rows r >= conf_rows are skipped.
- Completion: after the last row, go to DONE. DONE holds done_o=1 for one cycle, then returns to IDLE. busy_o is low the cycle after DONE.
- Counters: w and r are held until the matching rvalid. A grant and rvalid in the same cycle (zero-latency slave) are legal and must not lose or duplicate a beat.
- Out-of-range configuration: conf_rows is clamped to N_ROWS and conf_cols to RLEN/32. A value of 0 is treated as 1.
- Reset mid-operation: immediate return to IDLE. No further requests are issued, and a late rvalid is ignored. The register file may contain partial rows.
- mem_err_i without the optional feature: ignored; the data is used as returned.

Optional Feature:
- Macro: QUADRILATERO_LSU_ERR_EN.
- When defined: mem_err_i with rvalid aborts the instruction.
  - No further requests or rf writes; the current load row is not written.
  - Go to DONE. err_o pulses in the same cycle as done_o.
- Also flagged: instr_addr_i or instr_stride_i not 4-byte aligned at start_i. Such an instruction completes in 2 cycles (DONE + err_o) with no memory traffic.
- When undefined: the err_o port is absent, errors are ignored, and low address bits are dropped.

Test Plan:
- Load, N_ROWS=4, RLEN=128, addr 0x1000, stride 0x10, rows 2, cols 2, zero-latency slave → requests 0x1000, 0x1004, 0x1010, 0x1014. rf writes rows 0..3; rows 0–1 have words 2–3 zero; rows 2–3 are all zero. One done_o pulse; busy_o high the cycle after start.
- Store, rows 4, cols 4, stride 0x40, rf row r = {4 words r*4+3..r*4} → 16 writes at 0x2000 + 0x40*r + 4w, with mem_wdata_o matching the words, mem_be_o=F.
- Grant stall: mem_gnt_i low for 3 cycles on each request → address and data stable while stalled; no duplicate requests; final rf data correct.
- start_i pulsed while busy → ignored; only the first instruction's traffic; one done_o.
- Address wrap: addr 0xFFFFFFF8, cols 4 → addresses FFFFFFF8, FFFFFFFC, 00000000, 00000004.
- With QUADRILATERO_LSU_ERR_EN: mem_err_i on the 2nd beat of a load → no rf_we_o for that row; err_o and done_o in the same cycle; IDLE after.
